// File: rtl/rvx_core_trap_unit_pkg.sv
// Shared cause codes, mtvec mode, FSM state type and trap-target helper
// for the RVX core trap controller.
package rvx_core_trap_unit_pkg;

    // Exception cause codes (mcause[31] = 0)
    localparam logic [4:0] RVX_CAUSE_MISALIGNED_INSTRUCTION = 5'd0;
    localparam logic [4:0] RVX_CAUSE_ILLEGAL_INSTRUCTION    = 5'd2;
    localparam logic [4:0] RVX_CAUSE_BREAKPOINT             = 5'd3;
    localparam logic [4:0] RVX_CAUSE_MISALIGNED_LOAD        = 5'd4;
    localparam logic [4:0] RVX_CAUSE_MISALIGNED_STORE       = 5'd6;
    localparam logic [4:0] RVX_CAUSE_ECALL_MMODE            = 5'd11;

    // Interrupt cause codes (mcause[31] = 1); also the matching mie bit index
    localparam logic [4:0] RVX_CAUSE_SOFTWARE_INTERRUPT     = 5'd3;
    localparam logic [4:0] RVX_CAUSE_TIMER_INTERRUPT        = 5'd7;
    localparam logic [4:0] RVX_CAUSE_EXTERNAL_INTERRUPT     = 5'd11;
    localparam logic [4:0] RVX_CAUSE_FAST_BASE              = 5'd16;

    // mtvec[1:0] encoding that selects vectored interrupt dispatch
    localparam logic [1:0] RVX_MTVEC_MODE_VECTORED          = 2'b01;

    // Trap controller FSM states
    typedef enum logic [1:0] {
        TRAP_IDLE    = 2'd0,
        TRAP_HOLD    = 2'd1,
        TRAP_RESPOND = 2'd2
    } rvx_trap_state_e;

    // Result of a priority encoder: is anything requesting, and which cause
    typedef struct packed {
        logic       valid;
        logic       is_interrupt;
        logic [4:0] cause;
    } rvx_trap_sel_t;

    // Direct mode jumps to the aligned base; vectored interrupts add cause*4.
    // Modes 2 and 3 fall through to direct.
    function automatic logic [31:0] rvx_trap_target(
        input logic [31:0] mtvec,
        input logic [4:0]  cause,
        input logic        is_interrupt
    );
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (is_interrupt && (mtvec[1:0] == RVX_MTVEC_MODE_VECTORED)) begin
            return base + {25'd0, cause, 2'b00};
        end
        return base;
    endfunction

endpackage

// File: rtl/rvx_core_trap_unit_edge_latch.sv
// Pending logic for one fast interrupt channel: either a transparent level
// or a sticky bit set by a rising edge and cleared by the service pulse.
module rvx_core_trap_edge_latch #(
    parameter bit EDGE_MODE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic line,
    input  logic clear,
    output logic pending
);

    logic previous;
    logic sticky;
    logic rise;

    assign rise = line & ~previous;

    // Remember last line value and hold the edge until serviced; a new edge
    // in the clearing cycle keeps the bit set.
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            previous <= 1'b0;
            sticky   <= 1'b0;
        end else begin
            previous <= line;
            sticky   <= rise | (sticky & ~clear);
        end
    end

    assign pending = EDGE_MODE ? sticky : line;

endmodule

// File: rtl/rvx_core_trap_unit.sv
// RVX core trap controller: fast-IRQ pending capture, fixed-priority
// exception/interrupt arbitration, cause hold until trap entry, one-cycle
// service response, and direct/vectored trap target computation.
module rvx_core_trap_unit
    import rvx_core_trap_unit_pkg::*;
#(
    parameter int                      NUM_FAST_IRQ       = 16,
    parameter logic [NUM_FAST_IRQ-1:0] FAST_IRQ_EDGE_MASK = {NUM_FAST_IRQ{1'b0}}
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       irq_external_s1,
    input  logic                       irq_timer_s1,
    input  logic                       irq_software_s1,
    input  logic [NUM_FAST_IRQ-1:0]    irq_fast_s1,
    input  logic [16+NUM_FAST_IRQ-1:0] mie_s1,
    input  logic                       global_interrupt_enable_s1,
    input  logic                       misaligned_instruction_address_s1,
    input  logic                       illegal_instruction_s1,
    input  logic                       ebreak_s1,
    input  logic                       ecall_s1,
    input  logic                       misaligned_load_s1,
    input  logic                       misaligned_store_s1,
    input  logic                       trap_ack_s1,
    input  logic [31:0]                mtvec_s1,
    output logic                       take_trap_s1,
    output logic [4:0]                 trap_cause_s1,
    output logic                       trap_is_interrupt_s1,
    output logic [31:0]                trap_target_s1,
    output logic                       irq_external_response_s1,
    output logic                       irq_timer_response_s1,
    output logic                       irq_software_response_s1,
    output logic [NUM_FAST_IRQ-1:0]    irq_fast_response_s1
);

    rvx_trap_state_e          state;
    rvx_trap_state_e          next_state;
    logic [4:0]               held_cause;
    logic                     held_is_interrupt;
    logic [4:0]               next_held_cause;
    logic                     next_held_is_interrupt;

    logic [NUM_FAST_IRQ-1:0]  fast_pending;
    logic [NUM_FAST_IRQ-1:0]  fast_enabled;
    rvx_trap_sel_t            exception_sel;
    rvx_trap_sel_t            interrupt_sel;
    rvx_trap_sel_t            trap_sel;

    // mie bits that carry no interrupt source in this core
    logic unused_mie_bits;
    assign unused_mie_bits = ^{mie_s1[15:12], mie_s1[10:8], mie_s1[6:4], mie_s1[2:0]};

    // Per-channel pending capture, level or edge as configured
    for (genvar k = 0; k < NUM_FAST_IRQ; k++) begin : g_fast
        rvx_core_trap_edge_latch #(
            .EDGE_MODE (FAST_IRQ_EDGE_MASK[k])
        ) u_edge_latch (
            .clock   (clock),
            .reset   (reset),
            .line    (irq_fast_s1[k]),
            .clear   (irq_fast_response_s1[k]),
            .pending (fast_pending[k])
        );
    end

    assign fast_enabled = fast_pending & mie_s1[16 +: NUM_FAST_IRQ]
                        & {NUM_FAST_IRQ{global_interrupt_enable_s1}};

    // Exception priority encoder; later assignments win, so lowest priority first.
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        exception_sel = '0;
        if (misaligned_store_s1) begin
            exception_sel = '{valid: 1'b1, is_interrupt: 1'b0, cause: RVX_CAUSE_MISALIGNED_STORE};
        end
        if (misaligned_load_s1) begin
            exception_sel = '{valid: 1'b1, is_interrupt: 1'b0, cause: RVX_CAUSE_MISALIGNED_LOAD};
        end
        if (ecall_s1) begin
            exception_sel = '{valid: 1'b1, is_interrupt: 1'b0, cause: RVX_CAUSE_ECALL_MMODE};
        end
        if (ebreak_s1) begin
            exception_sel = '{valid: 1'b1, is_interrupt: 1'b0, cause: RVX_CAUSE_BREAKPOINT};
        end
        if (illegal_instruction_s1) begin
            exception_sel = '{valid: 1'b1, is_interrupt: 1'b0, cause: RVX_CAUSE_ILLEGAL_INSTRUCTION};
        end
        if (misaligned_instruction_address_s1) begin
            exception_sel = '{valid: 1'b1, is_interrupt: 1'b0, cause: RVX_CAUSE_MISALIGNED_INSTRUCTION};
        end
    end

    // Interrupt priority encoder: timer < software < external < fast (low index highest)
    always_comb begin
        interrupt_sel = '0;
        if (global_interrupt_enable_s1 && irq_timer_s1 && mie_s1[RVX_CAUSE_TIMER_INTERRUPT]) begin
            interrupt_sel = '{valid: 1'b1, is_interrupt: 1'b1, cause: RVX_CAUSE_TIMER_INTERRUPT};
        end
        if (global_interrupt_enable_s1 && irq_software_s1 && mie_s1[RVX_CAUSE_SOFTWARE_INTERRUPT]) begin
            interrupt_sel = '{valid: 1'b1, is_interrupt: 1'b1, cause: RVX_CAUSE_SOFTWARE_INTERRUPT};
        end
        if (global_interrupt_enable_s1 && irq_external_s1 && mie_s1[RVX_CAUSE_EXTERNAL_INTERRUPT]) begin
            interrupt_sel = '{valid: 1'b1, is_interrupt: 1'b1, cause: RVX_CAUSE_EXTERNAL_INTERRUPT};
        end
        for (int k = NUM_FAST_IRQ - 1; k >= 0; k--) begin
            if (fast_enabled[k]) begin
                interrupt_sel = '{valid: 1'b1, is_interrupt: 1'b1, cause: RVX_CAUSE_FAST_BASE + 5'(k)};
            end
        end
    end

    // Any exception beats any interrupt
    assign trap_sel = exception_sel.valid ? exception_sel : interrupt_sel;

    // FSM state and held cause registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= TRAP_IDLE;
            held_cause        <= 5'd0;
            held_is_interrupt <= 1'b0;
        end else begin
            state             <= next_state;
            held_cause        <= next_held_cause;
            held_is_interrupt <= next_held_is_interrupt;
        end
    end

    // Next-state, cause hold/recapture, and response pulse generation
    always_comb begin
        next_state               = state;
        next_held_cause          = held_cause;
        next_held_is_interrupt   = held_is_interrupt;
        take_trap_s1             = 1'b0;
        trap_cause_s1            = held_cause;
        trap_is_interrupt_s1     = held_is_interrupt;
        irq_external_response_s1 = 1'b0;
        irq_timer_response_s1    = 1'b0;
        irq_software_response_s1 = 1'b0;
        irq_fast_response_s1     = '0;

        unique case (state)
            TRAP_IDLE: begin
                take_trap_s1         = trap_sel.valid;
                trap_cause_s1        = trap_sel.cause;
                trap_is_interrupt_s1 = trap_sel.is_interrupt;
                if (trap_sel.valid) begin
                    next_held_cause        = trap_sel.cause;
                    next_held_is_interrupt = trap_sel.is_interrupt;
                    next_state             = trap_ack_s1 ? TRAP_RESPOND : TRAP_HOLD;
                end
            end

            TRAP_HOLD: begin
                take_trap_s1 = 1'b1;
                // Exceptions stay live while holding and displace a held interrupt
                if (exception_sel.valid) begin
                    trap_cause_s1          = exception_sel.cause;
                    trap_is_interrupt_s1   = 1'b0;
                    next_held_cause        = exception_sel.cause;
                    next_held_is_interrupt = 1'b0;
                end
                if (trap_ack_s1) begin
                    next_state = TRAP_RESPOND;
                end else if (!trap_sel.valid) begin
                    next_state = TRAP_IDLE;
                end
            end

            TRAP_RESPOND: begin
                if (held_is_interrupt) begin
                    case (held_cause)
                        RVX_CAUSE_EXTERNAL_INTERRUPT: irq_external_response_s1 = 1'b1;
                        RVX_CAUSE_TIMER_INTERRUPT:    irq_timer_response_s1    = 1'b1;
                        RVX_CAUSE_SOFTWARE_INTERRUPT: irq_software_response_s1 = 1'b1;
                        default: ;
                    endcase
                    for (int k = 0; k < NUM_FAST_IRQ; k++) begin
                        if (held_cause == RVX_CAUSE_FAST_BASE + 5'(k)) begin
                            irq_fast_response_s1[k] = 1'b1;
                        end
                    end
                end
                next_state = TRAP_IDLE;
            end

            default: begin
                next_state = TRAP_IDLE;
            end
        endcase
    end

    assign trap_target_s1 = rvx_trap_target(mtvec_s1, trap_cause_s1, trap_is_interrupt_s1);

endmodule

// File: tb/tb_rvx_core_trap_unit.sv
// Directed bench for rvx_core_trap_unit: expected outputs are queued when
// stimulus is applied and compared when the DUT presents the result.
module tb_rvx_core_trap_unit;

    localparam int             NF        = 16;
    localparam logic [NF-1:0]  EDGE_MASK = 16'h0004;

    logic            clock = 1'b0;
    logic            reset;
    logic            irq_external, irq_timer, irq_software;
    logic [NF-1:0]   irq_fast;
    logic [16+NF-1:0] mie;
    logic            gie;
    logic            exc_instr, exc_illegal, exc_ebreak, exc_ecall, exc_load, exc_store;
    logic            ack;
    logic [31:0]     mtvec;
    logic            take_trap;
    logic [4:0]      trap_cause;
    logic            trap_is_int;
    logic [31:0]     trap_target;
    logic            ext_resp, timer_resp, sw_resp;
    logic [NF-1:0]   fast_resp;

    typedef struct packed {
        logic          take;
        logic [4:0]    cause;
        logic          is_int;
        logic [31:0]   target;
        logic [2:0]    std_resp;   // {external, timer, software}
        logic [NF-1:0] fast_resp;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    rvx_core_trap_unit #(
        .NUM_FAST_IRQ       (NF),
        .FAST_IRQ_EDGE_MASK (EDGE_MASK)
    ) dut (
        .clock                             (clock),
        .reset                             (reset),
        .irq_external_s1                   (irq_external),
        .irq_timer_s1                      (irq_timer),
        .irq_software_s1                   (irq_software),
        .irq_fast_s1                       (irq_fast),
        .mie_s1                            (mie),
        .global_interrupt_enable_s1        (gie),
        .misaligned_instruction_address_s1 (exc_instr),
        .illegal_instruction_s1            (exc_illegal),
        .ebreak_s1                         (exc_ebreak),
        .ecall_s1                          (exc_ecall),
        .misaligned_load_s1                (exc_load),
        .misaligned_store_s1               (exc_store),
        .trap_ack_s1                       (ack),
        .mtvec_s1                          (mtvec),
        .take_trap_s1                      (take_trap),
        .trap_cause_s1                     (trap_cause),
        .trap_is_interrupt_s1              (trap_is_int),
        .trap_target_s1                    (trap_target),
        .irq_external_response_s1          (ext_resp),
        .irq_timer_response_s1             (timer_resp),
        .irq_software_response_s1          (sw_resp),
        .irq_fast_response_s1              (fast_resp)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic take, input logic [4:0] cause,
                        input logic is_int, input logic [31:0] target,
                        input logic [2:0] std_r, input logic [NF-1:0] fast_r);
        exp_t e;
        e = '{take: take, cause: cause, is_int: is_int, target: target,
              std_resp: std_r, fast_resp: fast_r};
        sb.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare_outputs();
        exp_t  e;
        string t;
        n_checks++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_underflow: observed empty queue expected an entry");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            t = tag_q.pop_front();
            check({t, ".take"},      32'(take_trap),   32'(e.take));
            check({t, ".cause"},     32'(trap_cause),  32'(e.cause));
            check({t, ".is_int"},    32'(trap_is_int), 32'(e.is_int));
            check({t, ".target"},    trap_target,      e.target);
            check({t, ".std_resp"},  32'({ext_resp, timer_resp, sw_resp}), 32'(e.std_resp));
            check({t, ".fast_resp"}, 32'(fast_resp),   32'(e.fast_resp));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic observe();
        #1;
        compare_outputs();
    endtask

    // Wait (bounded) until some response pulse is visible, then compare
    task automatic wait_response(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (|{ext_resp, timer_resp, sw_resp, fast_resp}) seen = 1'b1;
            else tick();
        end
        n_checks++;
        assert (seen === 1'b1) else begin
            n_fail++;
            $error("FAIL response_timeout: observed no pulse in %0d cycles expected a pulse", budget);
        end
        if (seen) begin
            observe();
        end else if (sb.size() > 0) begin
            void'(sb.pop_front());
            void'(tag_q.pop_front());
        end
    endtask

    initial begin
        reset = 1'b1;
        {irq_external, irq_timer, irq_software} = '0;
        irq_fast = '0;
        mie      = '1;
        gie      = 1'b0;
        {exc_instr, exc_illegal, exc_ebreak, exc_ecall, exc_load, exc_store} = '0;
        ack      = 1'b0;
        mtvec    = 32'h0000_1000;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        push("reset", 1'b0, 5'd0, 1'b0, 32'h0000_1000, 3'b000, '0);
        observe();

        // Exceptions beat an enabled timer interrupt; illegal beats load misaligned
        gie = 1'b1; exc_illegal = 1'b1; exc_load = 1'b1; irq_timer = 1'b1;
        push("exc_prio", 1'b1, 5'd2, 1'b0, 32'h0000_1000, 3'b000, '0);
        observe();
        ack = 1'b1;
        tick();
        ack = 1'b0; exc_illegal = 1'b0; exc_load = 1'b0; irq_timer = 1'b0;
        push("exc_respond", 1'b0, 5'd2, 1'b0, 32'h0000_1000, 3'b000, '0);
        observe();
        tick();
        push("exc_after", 1'b0, 5'd0, 1'b0, 32'h0000_1000, 3'b000, '0);
        observe();

        // Fast channel 5 beats external and timer
        irq_external = 1'b1; irq_timer = 1'b1; irq_fast[5] = 1'b1;
        push("irq_prio", 1'b1, 5'd21, 1'b1, 32'h0000_1000, 3'b000, '0);
        observe();
        tick();
        push("irq_hold", 1'b1, 5'd21, 1'b1, 32'h0000_1000, 3'b000, '0);
        observe();
        ack = 1'b1;
        tick();
        ack = 1'b0; irq_external = 1'b0; irq_timer = 1'b0; irq_fast[5] = 1'b0;
        push("irq_fast5_pulse", 1'b0, 5'd21, 1'b1, 32'h0000_1000, 3'b000, 16'h0020);
        wait_response(4);
        tick();
        push("irq_pulse_end", 1'b0, 5'd0, 1'b0, 32'h0000_1000, 3'b000, '0);
        observe();

        // Edge channel 2 latched while globally disabled
        gie = 1'b0; irq_fast[2] = 1'b1;
        tick();
        irq_fast[2] = 1'b0;
        repeat (10) tick();
        push("edge_masked", 1'b0, 5'd0, 1'b0, 32'h0000_1000, 3'b000, '0);
        observe();
        gie = 1'b1;
        push("edge_take", 1'b1, 5'd18, 1'b1, 32'h0000_1000, 3'b000, '0);
        observe();
        ack = 1'b1;
        tick();
        ack = 1'b0; irq_fast[2] = 1'b1;   // new edge in the clearing cycle
        push("edge_pulse", 1'b0, 5'd18, 1'b1, 32'h0000_1000, 3'b000, 16'h0004);
        wait_response(4);
        tick();
        irq_fast[2] = 1'b0;
        push("edge_rearm", 1'b1, 5'd18, 1'b1, 32'h0000_1000, 3'b000, '0);
        observe();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        push("edge_pulse2", 1'b0, 5'd18, 1'b1, 32'h0000_1000, 3'b000, 16'h0004);
        wait_response(4);
        tick();
        push("edge_cleared", 1'b0, 5'd0, 1'b0, 32'h0000_1000, 3'b000, '0);
        observe();

        // Software held for 3 cycles while external rises
        irq_software = 1'b1;
        push("hold_take", 1'b1, 5'd3, 1'b1, 32'h0000_1000, 3'b000, '0);
        observe();
        tick();
        irq_external = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("hold_keep", 1'b1, 5'd3, 1'b1, 32'h0000_1000, 3'b000, '0);
            observe();
            if (i == 2) ack = 1'b1;
            tick();
        end
        ack = 1'b0; irq_software = 1'b0; irq_external = 1'b0;
        push("hold_sw_pulse", 1'b0, 5'd3, 1'b1, 32'h0000_1000, 3'b001, '0);
        wait_response(4);
        tick();
        push("hold_done", 1'b0, 5'd0, 1'b0, 32'h0000_1000, 3'b000, '0);
        observe();

        // Source drops during HOLD: back to IDLE, late ack ignored
        irq_software = 1'b1;
        push("drop_take", 1'b1, 5'd3, 1'b1, 32'h0000_1000, 3'b000, '0);
        observe();
        tick();
        irq_software = 1'b0;
        push("drop_hold", 1'b1, 5'd3, 1'b1, 32'h0000_1000, 3'b000, '0);
        observe();
        tick();
        push("drop_idle", 1'b0, 5'd0, 1'b0, 32'h0000_1000, 3'b000, '0);
        observe();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        push("drop_no_pulse", 1'b0, 5'd0, 1'b0, 32'h0000_1000, 3'b000, '0);
        observe();

        // Vectored and direct target computation, all within one IDLE cycle
        mtvec = 32'h0000_1001; irq_timer = 1'b1;
        push("vec_timer", 1'b1, 5'd7, 1'b1, 32'h0000_101C, 3'b000, '0);
        observe();
        irq_timer = 1'b0; exc_ecall = 1'b1;
        push("vec_ecall", 1'b1, 5'd11, 1'b0, 32'h0000_1000, 3'b000, '0);
        observe();
        exc_ecall = 1'b0; mtvec = 32'h0000_1003; irq_timer = 1'b1;
        push("mode3_direct", 1'b1, 5'd7, 1'b1, 32'h0000_1000, 3'b000, '0);
        observe();
        irq_timer = 1'b0; mtvec = 32'h0000_1000;
        tick();

        // Per-cause enable masks the timer
        mie[7] = 1'b0; irq_timer = 1'b1;
        push("mie_masked", 1'b0, 5'd0, 1'b0, 32'h0000_1000, 3'b000, '0);
        observe();
        irq_timer = 1'b0; mie = '1;
        tick();

        // Reset while holding: IDLE next cycle, ack during reset gives no pulse
        irq_software = 1'b1;
        tick();
        push("rst_hold", 1'b1, 5'd3, 1'b1, 32'h0000_1000, 3'b000, '0);
        observe();
        reset = 1'b1; ack = 1'b1; irq_software = 1'b0;
        tick();
        reset = 1'b0; ack = 1'b0;
        push("rst_state", 1'b0, 5'd0, 1'b0, 32'h0000_1000, 3'b000, '0);
        observe();
        tick();
        push("rst_no_pulse", 1'b0, 5'd0, 1'b0, 32'h0000_1000, 3'b000, '0);
        observe();

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
